// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter only has to reach n-1; floor at 1 bit keeps the vector legal.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_16_if.sv
// Request/response bundle of the serial subtractor. The requester drives the
// operands and consumes the result; the subtractor is the slave side.
interface serial_subtractor_16_if #(
    parameter int N = serial_arith_pkg::DEFAULT_WIDTH
);
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] minuend;
    logic [N-1:0] subtrahend;
    logic         bin;
    logic         done_valid;
    logic         done_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output start_valid, minuend, subtrahend, bin, done_ready,
        input  start_ready, done_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  start_valid, minuend, subtrahend, bin, done_ready,
        output start_ready, done_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor_16_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out of the bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_16.sv
// Bit-serial subtractor: A - B - bin computed LSB first, one bit per clock,
// with borrow, signed-overflow and zero flags on the result handshake.
module serial_subtractor_16
    import serial_arith_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_subtractor_16_if.slave bus
);
    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic          borrow;
    logic          a_msb;
    logic          b_msb;
    logic [CW-1:0] cnt;

    logic [N-1:0]  diff_q;
    logic          bout_q;
    logic          ovf_q;
    logic          zero_q;

    logic          d_bit;
    logic          borrow_next;
    logic [N-1:0]  result_next;
    logic          accept;
    logic          last_bit;

    // Single bit slice shared by every iteration of the serial loop.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (borrow_next)
    );

    assign result_next = {d_bit, r_sr[N-1:1]};
    assign accept      = (state == ST_IDLE) && bus.start_valid;
    assign last_bit    = (state == ST_RUN) && (cnt == CNT_LAST);

    // FSM, operand shifting and result capture.
    // NOTE: every register here, including the shift registers, is reset so a
    // mid-operation reset leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sr   <= bus.minuend;
                        b_sr   <= bus.subtrahend;
                        r_sr   <= '0;
                        borrow <= bus.bin;
                        a_msb  <= bus.minuend[N-1];
                        b_msb  <= bus.subtrahend[N-1];
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= result_next;
                    borrow <= borrow_next;
                    if (last_bit) begin
                        // Counter is left at N-1 rather than wrapping.
                        diff_q <= result_next;
                        bout_q <= borrow_next;
                        ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ result_next[N-1]);
                        zero_q <= (result_next == '0);
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == ST_IDLE);
    assign bus.done_valid  = (state == ST_DONE);
    assign bus.diff        = diff_q;
    assign bus.bout        = bout_q;
    assign bus.ovf         = ovf_q;
    assign bus.zero        = zero_q;

endmodule

// File: tb/tb_serial_subtractor_16.sv
// Directed bench for serial_subtractor_16: reset/idle, arithmetic vectors with
// hand-computed results, latency, backpressure, ignored requests, mid-run reset.
module tb_serial_subtractor_16;

    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_subtractor_16_if #(.N(N)) bus ();

    serial_subtractor_16 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [15:0] exp_diff);
        check({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
        check({tag, "_done_valid"},  32'(bus.done_valid),  32'd0);
        check({tag, "_diff"},        32'(bus.diff),        32'(exp_diff));
    endtask

    // Issue one request, measure latency, check the result, then consume it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] exp_diff, input logic exp_bout,
                          input logic exp_ovf, input logic exp_zero);
        int cycles;
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.minuend     = a;
        bus.subtrahend  = b;
        bus.bin         = bi;
        bus.done_ready  = 1'b0;
        @(posedge clk);
        #1;
        // Operands are only required to be valid in the acceptance cycle.
        bus.start_valid = 1'b0;
        bus.minuend     = ~a;
        bus.subtrahend  = ~b;
        bus.bin         = ~bi;
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done_valid) break;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd16);
        check({tag, "_diff"},    32'(bus.diff), 32'(exp_diff));
        check({tag, "_bout"},    32'(bus.bout), 32'(exp_bout));
        check({tag, "_ovf"},     32'(bus.ovf),  32'(exp_ovf));
        check({tag, "_zero"},    32'(bus.zero), 32'(exp_zero));
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        check({tag, "_back_idle"}, 32'({bus.start_ready, bus.done_valid}), 32'b10);
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.minuend     = '0;
        bus.subtrahend  = '0;
        bus.bin         = 1'b0;
        bus.done_ready  = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check_idle_outputs("reset", 16'h0000);
        check("reset_flags", 32'({bus.bout, bus.ovf, bus.zero}), 32'd0);

        // Idle with no requests.
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle_outputs("idle20", 16'h0000);
        check("idle20_flags", 32'({bus.bout, bus.ovf, bus.zero}), 32'd0);

        run_op("basic",      16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("underflow",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf_neg",    16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_pos",    16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("bin_zero",   16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("bin_wrap",   16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Backpressure and ignored requests: 0xABCD - 0x1234 = 0x9999.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.minuend     = 16'hABCD;
        bus.subtrahend  = 16'h1234;
        bus.bin         = 1'b0;
        @(posedge clk);
        #1;
        // Toggle requests with different operands throughout RUN.
        for (int i = 0; i < 15; i++) begin
            bus.start_valid = i[0];
            bus.minuend     = 16'h1111 * 16'(i);
            bus.subtrahend  = 16'hFFFF;
            @(posedge clk);
            #1;
            if (i == 7) begin
                check("run_busy", 32'({bus.start_ready, bus.done_valid}), 32'b00);
                check("run_holds_prev", 32'({bus.diff, bus.zero}), 32'h00001);
            end
        end
        @(posedge clk);
        #1;
        check("bp_arrive", 32'(bus.done_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = ~bus.start_valid;
            @(posedge clk);
            #1;
            check("bp_hold", 32'({bus.done_valid, bus.start_ready, bus.diff, bus.bout,
                                  bus.ovf, bus.zero}), {2'b10, 16'h9999, 3'b000, 11'd0} >> 11);
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        check("bp_release", 32'({bus.start_ready, bus.done_valid}), 32'b10);
        // Stray requests in RUN/DONE must not have started another operation.
        repeat (3) @(posedge clk);
        #1;
        check("no_stray_op", 32'({bus.start_ready, bus.done_valid, bus.diff}), {2'b10, 16'h9999});

        // Reset in the middle of RUN (counter at 7).
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.minuend     = 16'h1234;
        bus.subtrahend  = 16'h0234;
        bus.bin         = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst", 16'h0000);
        check("midrst_flags", 32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_result", 32'(bus.done_valid), 32'd0);
        run_op("after_rst", 16'h00FF, 16'h0F0F, 1'b0, 16'hF1F0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_16.md
# serial_subtractor_16

Bit-serial N-bit subtractor that computes minuend − subtrahend − borrow-in one bit per clock, LSB first. It is the subtraction counterpart to the parallel ripple adder in the datapath. It trades area for latency and is used by multi-cycle ALU operations (SUB/CMP) where a fixed N-cycle latency is acceptable. Operands enter through a valid/ready request handshake; results leave through a valid/ready response handshake with borrow, signed-overflow and zero flags.

## Interface
- N, default 16, operand and result width (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request valid
- start_ready  out  1  request accepted when both start_valid and start_ready are high
- minuend  in  N  operand A, sampled on acceptance
- subtrahend  in  N  operand B, sampled on acceptance
- bin  in  1  borrow-in, sampled on acceptance
- done_valid  out  1  result valid
- done_ready  in  1  result consumed when both done_valid and done_ready are high
- diff  out  N  A − B − bin, modulo 2^N
- bout  out  1  borrow out of MSB (1 ⇔ unsigned A < B + bin)
- ovf  out  1  signed overflow
- zero  out  1  diff == 0

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On acceptance: load A/B into right-shift registers, borrow register ← bin, latch A[N-1] and B[N-1], bit counter ← 0, go to RUN.
- RUN:
  - Each cycle, with a=A_sr[0], b=B_sr[0], br=borrow:
    - d = a^b^br
    - br' = (~a&b) | (~(a^b)&br)
  - d shifts into the MSB of the result shift register. A_sr/B_sr shift right. Counter increments.
  - On the cycle counter==N−1, go to DONE and load the output registers:
    - diff ← completed result
    - bout ← br'
    - ovf ← (A[N-1]^B[N-1]) & (A[N-1]^diff[N-1])
    - zero ← (diff==0)
- DONE:
  - done_valid=1; start_ready=0.
  - Hold until done_ready=1, then go to IDLE.
- diff/bout/ovf/zero change only on the RUN→DONE transition. They hold the last result through IDLE and the next RUN.
- start_valid is ignored outside IDLE. The operand inputs need only be stable in the acceptance cycle.
- Counter width is $clog2(N). It never wraps, because the RUN exit fires at N−1.

## Timing
- Reset (async assert, any state):
  - State → IDLE.
  - start_ready=1, done_valid=0, diff=0, bout=0, ovf=0, zero=0.
  - Counter and shift registers cleared.
  - Reset mid-RUN or mid-DONE discards the operation; no result is produced.
- Latency: if acceptance happens at edge E0, done_valid is high after edge E_N, i.e. N cycles later (16 for N=16).
- Throughput:
  - One operation per N+2 cycles with done_ready held high.
  - The DONE→IDLE edge is followed by one IDLE cycle with start_ready=1. A new request cannot be accepted in the same cycle as the result handshake.
- Backpressure: in DONE with done_ready=0, all outputs are stable indefinitely.

## Structure
- Shared package serial_arith_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default width constant (16)
  - counter-width function/localparam
- Sub-module full_subtractor (1-bit: a, b, bin → d, bout) implements the per-bit equations. It is instantiated once inside the serial loop.
- Everything else is registers plus FSM in the top module.

## Test plan
- Reset and idle:
  - rst_n low → all outputs at their reset values, start_ready=1.
  - Release reset with start_valid=0 for 20 cycles → no change.
- Basic subtraction:
  - A=0x1234, B=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0, zero=0.
  - done_valid rises exactly 16 cycles after the acceptance edge.
- Unsigned underflow: A=0x0000, B=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0, zero=0.
- Signed overflow:
  - A=0x8000, B=0x0001 → diff=0x7FFF, bout=0, ovf=1.
  - A=0x7FFF, B=0xFFFF → diff=0x8000, bout=1, ovf=1.
- Borrow-in and zero:
  - A=0x0005, B=0x0004, bin=1 → diff=0x0000, zero=1, bout=0.
  - A=0x0000, B=0xFFFF, bin=1 → diff=0x0000, bout=1, zero=1.
- Handshake and reset:
  - Hold done_ready=0 for 5 cycles → outputs stable. Toggle start_valid in RUN/DONE → ignored.
  - Assert rst_n low at counter=7 → done_valid=0 and start_ready=1 immediately. The next operation completes with a correct result.
